// File: rtl/ofdm_qam_mapper.sv
// Gray-coded BPSK/QPSK/16QAM/64QAM constellation mapper: serialises one interleaved block into I/Q samples.
// Optional build macro MAPPER_NORM_EN selects unit-average-power Q2.6 levels instead of raw odd integers.
module ofdm_qam_mapper #(
  parameter int unsigned blk_size = 384,
  parameter int unsigned out_w    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [blk_size-1:0]     in_blk,
  input  logic                    in_blk_valid,
  input  logic [2:0]              rate_id,
  output logic                    in_blk_ready,
  output logic signed [out_w-1:0] out_i,
  output logic signed [out_w-1:0] out_q,
  output logic [1:0]              out_mod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    rate_err
);

  localparam int unsigned CNT_W = $clog2(blk_size);
  localparam logic [1:0] MOD_BPSK  = 2'd0;
  localparam logic [1:0] MOD_QPSK  = 2'd1;
  localparam logic [1:0] MOD_QAM16 = 2'd2;
  localparam logic [1:0] MOD_QAM64 = 2'd3;

  typedef enum logic {S_IDLE, S_MAP} state_t;

  state_t                    r_state;
  logic [blk_size-1:0]       r_buf;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          r_last_idx;
  logic                      r_ready;
  logic signed [out_w-1:0]   r_i;
  logic signed [out_w-1:0]   r_q;
  logic [1:0]                r_mod;
  logic                      r_valid;
  logic                      r_last;
  logic                      r_rate_err;

  logic [1:0]  w_acc_mod;
  logic [15:0] w_acc_sym;
  logic [15:0] w_nxt_sym;

  function automatic logic [1:0] rate_to_mod(input logic [2:0] rid);
    case (rid)
      3'd0:       return MOD_BPSK;
      3'd1, 3'd2: return MOD_QPSK;
      3'd3, 3'd4: return MOD_QAM16;
      default:    return MOD_QAM64;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] last_index(input logic [1:0] m);
    case (m)
      MOD_BPSK:  return CNT_W'(blk_size - 1);
      MOD_QPSK:  return CNT_W'(blk_size / 2 - 1);
      MOD_QAM16: return CNT_W'(blk_size / 4 - 1);
      default:   return CNT_W'(blk_size / 6 - 1);
    endcase
  endfunction

  // Drop the bits of the symbol just consumed so the next symbol sits at bit 0.
  function automatic logic [blk_size-1:0] shift_out(input logic [blk_size-1:0] b, input logic [1:0] m);
    case (m)
      MOD_BPSK:  return b >> 1;
      MOD_QPSK:  return b >> 2;
      MOD_QAM16: return b >> 4;
      default:   return b >> 6;
    endcase
  endfunction

  // One axis level; code is the MSB-first bit group {b0,b1,b2} with unused LSBs zero.
  function automatic logic [7:0] axis_level(input logic [1:0] m, input logic [2:0] code);
    logic       neg;
    logic [2:0] mag;
    logic [7:0] lvl;
    neg = 1'b0;
    mag = 3'd1;
    case (m)
      MOD_BPSK, MOD_QPSK: begin
        neg = code[2];
        mag = 3'd1;
      end
      MOD_QAM16: begin
        neg = ~code[2];
        mag = code[1] ? 3'd1 : 3'd3;
      end
      default: begin
        neg = ~code[2];
        case (code[1:0])
          2'b00:   mag = 3'd7;
          2'b01:   mag = 3'd5;
          2'b11:   mag = 3'd3;
          default: mag = 3'd1;
        endcase
      end
    endcase
`ifdef MAPPER_NORM_EN
    case (m)
      MOD_BPSK:  lvl = 8'd64;
      MOD_QPSK:  lvl = 8'd45;
      MOD_QAM16: lvl = (mag == 3'd1) ? 8'd20 : 8'd61;
      default: begin
        case (mag)
          3'd1:    lvl = 8'd10;
          3'd3:    lvl = 8'd30;
          3'd5:    lvl = 8'd49;
          default: lvl = 8'd69;
        endcase
      end
    endcase
`else
    lvl = 8'(mag);
`endif
    return neg ? 8'(8'd0 - lvl) : lvl;
  endfunction

  function automatic logic [15:0] map_symbol(input logic [1:0] m, input logic [5:0] b);
    logic [7:0] i;
    logic [7:0] q;
    i = axis_level(m, {b[0], b[1], b[2]});
    case (m)
      MOD_BPSK:  q = 8'd0;
      MOD_QPSK:  q = axis_level(m, {b[1], 2'b00});
      MOD_QAM16: q = axis_level(m, {b[2], b[3], 1'b0});
      default:   q = axis_level(m, {b[3], b[4], b[5]});
    endcase
    return {i, q};
  endfunction

  assign w_acc_mod = rate_to_mod(rate_id);
  assign w_acc_sym = map_symbol(w_acc_mod, in_blk[5:0]);
  assign w_nxt_sym = map_symbol(r_mod, r_buf[5:0]);

  // Block accept, symbol sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_last_idx <= '0;
      r_ready    <= 1'b0;
      r_i        <= '0;
      r_q        <= '0;
      r_mod      <= MOD_BPSK;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_rate_err <= 1'b0;
    end else begin
      r_rate_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (in_blk_valid && r_ready) begin
            if (rate_id == 3'd7) begin
              r_rate_err <= 1'b1;
            end else begin
              r_state    <= S_MAP;
              r_ready    <= 1'b0;
              r_mod      <= w_acc_mod;
              r_buf      <= shift_out(in_blk, w_acc_mod);
              r_cnt      <= '0;
              r_last_idx <= last_index(w_acc_mod);
              r_i        <= out_w'($signed(w_acc_sym[15:8]));
              r_q        <= out_w'($signed(w_acc_sym[7:0]));
              r_valid    <= 1'b1;
              r_last     <= 1'b0;
            end
          end
        end
        S_MAP: begin
          if (out_ready) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_cnt  <= r_cnt + CNT_W'(1);
              r_buf  <= shift_out(r_buf, r_mod);
              r_i    <= out_w'($signed(w_nxt_sym[15:8]));
              r_q    <= out_w'($signed(w_nxt_sym[7:0]));
              r_last <= ((r_cnt + CNT_W'(1)) == r_last_idx);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_blk_ready = r_ready;
  assign out_i        = r_i;
  assign out_q        = r_q;
  assign out_mod      = r_mod;
  assign out_valid    = r_valid;
  assign out_last     = r_last;
  assign rate_err     = r_rate_err;

endmodule

// File: doc/ofdm_qam_mapper.md
Name: ofdm_qam_mapper

Overview:
- Constellation mapper that sits directly downstream of the block interleaver in the WiMAX OFDM transmit chain.
- Accepts one interleaved coded block of blk_size bits, together with the burst rate_id.
- Serialises the block into Gray-mapped BPSK/QPSK/16-QAM/64-QAM I/Q samples, one per accepted output handshake, for the subcarrier allocator and IFFT stage.

Parameters:
- blk_size, 384, coded bits per input block; must be a multiple of 12.
- out_w, 8, signed I/Q sample width; fixed at 8, other values unsupported.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous active-low reset.
- in_blk  input  blk_size  interleaved block; bit 0 is transmitted first.
- in_blk_valid  input  1  in_blk and rate_id valid.
- rate_id  input  3  burst profile: 0 BPSK, 1-2 QPSK, 3-4 16QAM, 5-6 64QAM, 7 invalid.
- in_blk_ready  output  1  mapper can accept a block.
- out_i  output  8  signed in-phase sample.
- out_q  output  8  signed quadrature sample.
- out_mod  output  2  modulation of current sample: 0 BPSK, 1 QPSK, 2 16QAM, 3 64QAM.
- out_valid  output  1  sample valid.
- out_ready  input  1  downstream accepts sample.
- out_last  output  1  current sample is the last of the block.
- rate_err  output  1  one-cycle pulse when a rate_id=7 block is rejected.

Behaviour:
- Reset: a clk edge with reset=0 applies reset. Results:
  - state=IDLE; in_blk_ready=0 during reset and 1 on the first cycle after reset=1.
  - out_valid=0, out_last=0, rate_err=0, out_i=out_q=0, out_mod=0.
  - Symbol counter and block buffer cleared.
  - Reset mid-block discards the remaining symbols with no out_last.
- States:
  - IDLE: in_blk_ready=1.
  - MAP: in_blk_ready=0.
- Acceptance:
  - A block is accepted on a rising edge with in_blk_valid=1 and in_blk_ready=1.
  - in_blk, and bps derived from rate_id, are latched into the buffer at that edge.
  - bps per rate_id: 0→1, 1-2→2, 3-4→4, 5-6→6.
- Invalid rate: an accept with rate_id=7 is rejected.
  - Block dropped; state stays IDLE.
  - rate_err=1 for exactly the next cycle.
  - No output sample is produced.
- Block length: nsym=blk_size/bps. For blk_size=384: BPSK 384, QPSK 192, 16QAM 96, 64QAM 64.
- Symbol bit selection: symbol k uses buffer bits [k*bps +: bps]; b0 is the lowest index.
- Mapping, MSB-first pair/triple notation:
  - BPSK: I = b0 ? -1 : +1; Q = 0.
  - QPSK: I = b0 ? -1 : +1; Q = b1 ? -1 : +1.
  - 16QAM: I from (b0,b1), Q from (b2,b3). 00→-3, 01→-1, 11→+1, 10→+3.
  - 64QAM: I from (b0,b1,b2), Q from (b3,b4,b5). 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7.
- Latency: state enters MAP at the accept edge; symbol 0 is registered at that same edge. out_valid=1 on the cycle after acceptance (1-cycle latency).
- Output handshake:
  - A sample transfers when out_valid=1 and out_ready=1 at a rising edge.
  - While out_valid=1 and out_ready=0, out_i, out_q, out_mod and out_last hold stable.
  - Each transfer loads symbol k+1 into the output registers at the same edge, giving 1 sample/cycle with out_ready held high.
- out_last: 1 exactly when symbol nsym-1 is presented.
- End of block: on transfer of the last symbol, out_valid=0 and state=IDLE. in_blk_ready=1 on the following cycle, so there is one bubble cycle between blocks.
- Boundary conditions:
  - in_blk_valid during MAP is ignored, because in_blk_ready=0.
  - The symbol counter never exceeds nsym-1.
  - out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: MAPPER_NORM_EN.
- Defined: samples are normalised to unit average power, as Q2.6 with 64=1.0:
  - BPSK ±1→±64.
  - QPSK ±1→±45.
  - 16QAM ±1→±20, ±3→±61.
  - 64QAM ±1→±10, ±3→±30, ±5→±49, ±7→±69.
  - BPSK Q remains 0.
- Undefined: out_i/out_q carry the raw odd integer level sign-extended to 8 bits, e.g. -7→8'hF9. Downstream normalises using out_mod.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset sequence: hold reset=0 for 3 cycles, then release. Expected: in_blk_ready=1 on the first cycle after release; out_valid=0, rate_err=0, out_i=out_q=0 throughout.
- BPSK block with in_blk=384'h...0001 (bit0=1), rate_id=0, out_ready=1. Expected: out_valid one cycle after accept; 384 consecutive samples; sample0 I=-1; samples 1-383 I=+1; Q=0 throughout; out_last only on sample 383; in_blk_ready=1 one cycle after.
- 64QAM block with bits[5:0]=6'b000100, i.e. b2=1 so I triple 001 and Q triple 000, rate_id=5. Expected: sample0 I=-5, Q=-7, out_mod=3; 64 samples total; out_last on sample 63.
- Backpressure on 16QAM (rate_id=3): drop out_ready for 5 cycles after sample 10. Expected: sample 10 held stable for all 5 cycles; no samples skipped or duplicated; 96 samples total.
- Invalid rate: rate_id=7 with in_blk_valid=1. Expected: rate_err=1 for exactly one cycle; out_valid never asserts; in_blk_ready stays 1.
- Reset mid-block: QPSK block, assert reset after 50 samples. Expected: out_valid=0 and in_blk_ready=1 once reset is released. A new block then starts at symbol 0 with the correct first sample.
- Build with MAPPER_NORM_EN and repeat the 64QAM case. Expected: sample0 I=-49, Q=-69.
